// File: rtl/reg_wb_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
package reg_wb_ctrl_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned STARVE_W  = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    HOLD   = 1'b1
  } starve_state_e;

  function automatic logic [31:0] reg_onehot(input logic [4:0] idx);
    return 32'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_scoreboard.sv
// Pending-register scoreboard and outstanding long-latency op counter; raises
// the ID stall for RAW/WAW hazards on pending registers or when capacity is full.
module wb_scoreboard
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_long_i,
  input  logic [4:0] issue_rd_i,
  input  logic       lsu_acc_i,
  input  logic [4:0] lsu_waddr_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [4:0] id_rd_i,
  output logic       stall_o
);

  logic [31:0]      pending_q, pending_d, pending_eff;
  logic [31:0]      set_mask, clr_mask;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;

  always_comb begin
    set_mask = ZERO_WORD;
    clr_mask = ZERO_WORD;
    if (issue_long_i && (issue_rd_i != ZERO_REG)) set_mask = reg_onehot(issue_rd_i);
    if (lsu_acc_i) clr_mask = reg_onehot(lsu_waddr_i);
    // Register being written this cycle is forwarded by the RF, so it no longer stalls.
    pending_eff = pending_q & ~clr_mask;
    pending_d   = pending_eff | set_mask;

    count_d = count_q;
    if (issue_long_i && !lsu_acc_i && (count_q != CNT_W'(MAX_OUTST)))
      count_d = count_q + CNT_W'(1);
    else if (lsu_acc_i && !issue_long_i && (count_q != '0))
      count_d = count_q - CNT_W'(1);

    full    = (count_q == CNT_W'(MAX_OUTST));
    stall_o = rst_n & (pending_eff[id_rs1_i] | pending_eff[id_rs2_i] |
                       pending_eff[id_rd_i] | full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= ZERO_WORD;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(lsu_acc_i && (count_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_long_i && !lsu_acc_i && (count_q == CNT_W'(MAX_OUTST))));

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: shares the RF write port between EX and the long-latency
// path, with a starvation hold that guarantees the long-latency path is served.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_wen_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_ready_o,
  input  logic        issue_long_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  output logic        stall_o,
  output logic        ex_hold_o,
  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o
);

  starve_state_e       state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                lsu_acc;

  always_comb begin
    lsu_ready_o = rst_n & ~ex_wen_i;
    lsu_acc     = lsu_valid_i & lsu_ready_o;
    reg_wen_o   = 1'b0;
    reg_waddr_o = ZERO_REG;
    reg_wdata_o = ZERO_WORD;
    if (rst_n && ex_wen_i) begin
      reg_wen_o   = 1'b1;
      reg_waddr_o = ex_waddr_i;
      reg_wdata_o = ex_wdata_i;
    end else if (rst_n && lsu_valid_i) begin
      reg_wen_o   = 1'b1;
      reg_waddr_o = lsu_waddr_i;
      reg_wdata_o = lsu_wdata_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      NORMAL: begin
        if (lsu_valid_i && !lsu_ready_o) begin
          if (starve_q == STARVE_W'(STARVE_MAX - 1)) begin
            state_d  = HOLD;
            starve_d = '0;
          end else begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else begin
          starve_d = '0;
        end
      end
      HOLD: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
      default: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign ex_hold_o = (state_q == HOLD);

  wb_scoreboard #(.MAX_OUTST(MAX_OUTST)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_long_i (issue_long_i),
    .issue_rd_i   (issue_rd_i),
    .lsu_acc_i    (lsu_acc),
    .lsu_waddr_i  (lsu_waddr_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rd_i      (id_rd_i),
    .stall_o      (stall_o)
  );

  a_no_ex_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_hold_o && ex_wen_i));

endmodule
